// File: rtl/aim_pkg.sv
// ============================================================================
// Module      : aim_pkg
// Description : Key codes, FSM state and aim-operation types for the aim
//               controller, plus the keycode-to-operation decoder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package aim_pkg;

    localparam logic [7:0] KEY_PWR_UP = 8'd82;
    localparam logic [7:0] KEY_PWR_DN = 8'd81;
    localparam logic [7:0] KEY_ANG_UP = 8'd54;
    localparam logic [7:0] KEY_ANG_DN = 8'd55;
    localparam logic [7:0] KEY_FIRE   = 8'd44;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIRE = 2'd2
    } aim_state_t;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_PWR_UP = 3'd1,
        OP_PWR_DN = 3'd2,
        OP_ANG_UP = 3'd3,
        OP_ANG_DN = 3'd4,
        OP_FIRE   = 3'd5
    } aim_op_t;

    function automatic aim_op_t key_to_op(input logic [7:0] kc);
        aim_op_t op;
        case (kc)
            KEY_PWR_UP: op = OP_PWR_UP;
            KEY_PWR_DN: op = OP_PWR_DN;
            KEY_ANG_UP: op = OP_ANG_UP;
            KEY_ANG_DN: op = OP_ANG_DN;
            KEY_FIRE:   op = OP_FIRE;
            default:    op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic op_is_adjust(input aim_op_t op);
        return (op == OP_PWR_UP) || (op == OP_PWR_DN) ||
               (op == OP_ANG_UP) || (op == OP_ANG_DN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_repeat_gen.sv
// ============================================================================
// Module      : key_repeat_gen
// Description : Keycode decode and press-edge detection; with KEY_REPEAT_EN
//               defined, also a hold counter producing auto-repeat steps.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_repeat_gen
    import aim_pkg::*;
`ifdef KEY_REPEAT_EN
#(
    parameter int RPT_DELAY  = 8,
    parameter int RPT_PERIOD = 2
)
`endif
(
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       key_en,
    input  logic       in_hold,
    output aim_op_t    op,
    output logic       press,
    output logic       held,
    output logic       step
);

    logic [7:0] r_key_prev;
    logic       w_mapped;
    logic       w_rpt;

    assign op       = key_to_op(keycode);
    assign w_mapped = (op != OP_NONE);
    assign press    = w_mapped && (keycode != r_key_prev);
    assign held     = w_mapped && (keycode == r_key_prev);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_key_prev <= 8'd0;
        end else begin
            r_key_prev <= keycode;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int CW = $clog2(((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD) + 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_run;
    logic [CW-1:0] w_target;

    // r_cnt equals frames since the press (or since the last repeat) while held
    assign w_run    = key_en && in_hold && held;
    assign w_target = r_phase ? CW'(RPT_PERIOD) : CW'(RPT_DELAY);
    assign w_rpt    = w_run && (r_cnt == w_target);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt   <= CW'(1);
            r_phase <= 1'b0;
        end else if (!w_run) begin
            r_cnt   <= CW'(1);
            r_phase <= 1'b0;
        end else if (w_rpt) begin
            r_cnt   <= CW'(1);
            r_phase <= 1'b1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end
`else
    assign w_rpt = 1'b0;
`endif

    assign step = key_en && ((press && op_is_adjust(op)) || w_rpt);

endmodule

`default_nettype wire

// File: rtl/aim_ctrl_multi.sv
// ============================================================================
// Module      : aim_ctrl_multi
// Description : Per-player saturating power/angle aim registers with a
//               valid/ready fire snapshot. Define KEY_REPEAT_EN to enable
//               hold auto-repeat of adjust keys.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aim_ctrl_multi
    import aim_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int W          = 4,
    parameter int PWR_MAX    = 7,
    parameter int ANG_MAX    = 7,
    parameter int RPT_DELAY  = 8,
    parameter int RPT_PERIOD = 2,
    localparam int AW        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
)(
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic                 is_in_turn,
    input  logic [AW-1:0]        active_player,
    input  logic [7:0]           keycode,
    output logic [N_PLAYERS*W-1:0] power,
    output logic [N_PLAYERS*W-1:0] angle,
    output logic                 fire_valid,
    input  logic                 fire_ready,
    output logic [AW-1:0]        fire_player,
    output logic [W-1:0]         fire_power,
    output logic [W-1:0]         fire_angle
);

    if (N_PLAYERS < 1 || PWR_MAX >= 2**W || ANG_MAX >= 2**W ||
        RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_err
        $error("aim_ctrl_multi: illegal parameter combination");
    end

    aim_state_t r_state;
    aim_state_t w_state_nxt;
    logic [AW-1:0] r_prev_player;
    logic          w_pvalid;
    logic          w_gate;
    logic          w_key_en;
    logic          w_press;
    logic          w_held;
    logic          w_step;
    logic          w_fire_take;
    aim_op_t       w_op;
    logic [W-1:0]  w_sel_pwr;
    logic [W-1:0]  w_sel_ang;
    logic [AW-1:0] r_fire_player;
    logic [W-1:0]  r_fire_power;
    logic [W-1:0]  r_fire_angle;

    if (N_PLAYERS == 2**AW) begin : g_pvalid_full
        assign w_pvalid = 1'b1;
    end else begin : g_pvalid_cmp
        assign w_pvalid = (active_player < AW'(N_PLAYERS));
    end

    // A player switch blocks keys for that frame so a held key cannot leak across channels
    assign w_gate   = is_in_turn && w_pvalid && (active_player == r_prev_player);
    assign w_key_en = w_gate && (r_state != FIRE);

    key_repeat_gen
`ifdef KEY_REPEAT_EN
    #(
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    )
`endif
    u_keys (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .key_en    (w_key_en),
        .in_hold   (r_state == HOLD),
        .op        (w_op),
        .press     (w_press),
        .held      (w_held),
        .step      (w_step)
    );

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= IDLE;
            r_prev_player <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_player <= active_player;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire_take = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_key_en && w_press) begin
                    if (w_op == OP_FIRE) begin
                        w_state_nxt = FIRE;
                        w_fire_take = 1'b1;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!w_gate) begin
                    w_state_nxt = IDLE;
                end else if (w_press) begin
                    if (w_op == OP_FIRE) begin
                        w_state_nxt = FIRE;
                        w_fire_take = 1'b1;
                    end
                end else if (!w_held) begin
                    w_state_nxt = IDLE;
                end
            end
            FIRE: begin
                if (fire_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_chan
        logic [W-1:0] r_pwr;
        logic [W-1:0] r_ang;
        logic         w_sel;

        assign w_sel = w_step && (active_player == AW'(p));

        always_ff @(posedge frame_clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_pwr <= '0;
                r_ang <= '0;
            end else if (w_sel) begin
                case (w_op)
                    OP_PWR_UP: if (r_pwr < W'(PWR_MAX)) r_pwr <= r_pwr + 1'b1;
                    OP_PWR_DN: if (r_pwr != '0)         r_pwr <= r_pwr - 1'b1;
                    OP_ANG_UP: if (r_ang < W'(ANG_MAX)) r_ang <= r_ang + 1'b1;
                    OP_ANG_DN: if (r_ang != '0)         r_ang <= r_ang - 1'b1;
                    default: ;
                endcase
            end
        end

        assign power[p*W +: W] = r_pwr;
        assign angle[p*W +: W] = r_ang;
    end

    always_comb begin
        w_sel_pwr = '0;
        w_sel_ang = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (active_player == AW'(p)) begin
                w_sel_pwr = power[p*W +: W];
                w_sel_ang = angle[p*W +: W];
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fire_player <= '0;
            r_fire_power  <= '0;
            r_fire_angle  <= '0;
        end else if (w_fire_take) begin
            r_fire_player <= active_player;
            r_fire_power  <= w_sel_pwr;
            r_fire_angle  <= w_sel_ang;
        end
    end

    assign fire_valid  = (r_state == FIRE);
    assign fire_player = r_fire_player;
    assign fire_power  = r_fire_power;
    assign fire_angle  = r_fire_angle;

endmodule

`default_nettype wire

// File: tb/tb_aim_ctrl_multi.sv
// ============================================================================
// Module      : tb_aim_ctrl_multi
// Description : Directed self-checking bench for aim_ctrl_multi (2 players,
//               W=4, limits 7); hold expectations follow KEY_REPEAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aim_ctrl_multi;

    logic       frame_clk;
    logic       Reset_n;
    logic       is_in_turn;
    logic [0:0] active_player;
    logic [7:0] keycode;
    logic [7:0] power;
    logic [7:0] angle;
    logic       fire_valid;
    logic       fire_ready;
    logic [0:0] fire_player;
    logic [3:0] fire_power;
    logic [3:0] fire_angle;

    int n_cmp;
    int n_fail;

    aim_ctrl_multi #(
        .N_PLAYERS  (2),
        .W          (4),
        .PWR_MAX    (7),
        .ANG_MAX    (7),
        .RPT_DELAY  (8),
        .RPT_PERIOD (2)
    ) dut (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .is_in_turn    (is_in_turn),
        .active_player (active_player),
        .keycode       (keycode),
        .power         (power),
        .angle         (angle),
        .fire_valid    (fire_valid),
        .fire_ready    (fire_ready),
        .fire_player   (fire_player),
        .fire_power    (fire_power),
        .fire_angle    (fire_angle)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        tick();
        keycode = 8'd0;
        tick();
    endtask

    task automatic do_reset();
        Reset_n       = 1'b0;
        keycode       = 8'd0;
        fire_ready    = 1'b0;
        is_in_turn    = 1'b1;
        active_player = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset_n       = 1'b0;
        keycode       = 8'd0;
        fire_ready    = 1'b0;
        is_in_turn    = 1'b1;
        active_player = 1'b0;
        tick();
        n_cmp++;
        if (power !== 8'h00 || angle !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_aim: power=%h angle=%h expected 00 00", power, angle);
        end
        n_cmp++;
        if (fire_valid !== 1'b0 || fire_player !== 1'b0 || fire_power !== 4'h0 || fire_angle !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_fire: v=%b p=%h pw=%h an=%h expected all 0", fire_valid, fire_player, fire_power, fire_angle);
        end
        Reset_n = 1'b1;
        tick();
        keycode = 8'd82;
        tick();
        n_cmp++;
        if (power !== 8'h01) begin
            n_fail++;
            $display("FAIL first_step: power=%h expected 01", power);
        end
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (power !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_hold: power=%h expected 00", power);
        end
        keycode = 8'd0;
        tick();
        Reset_n = 1'b1;
        tick();
        press(8'd82);
        press(8'd82);
        keycode = 8'd44;
        tick();
        keycode = 8'd0;
        n_cmp++;
        if (fire_valid !== 1'b1 || fire_power !== 4'd2) begin
            n_fail++;
            $display("FAIL fire_before_reset: valid=%b power=%h expected 1 2", fire_valid, fire_power);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (fire_valid !== 1'b0 || fire_power !== 4'h0 || power !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_fire: valid=%b fpow=%h power=%h expected 0 0 00", fire_valid, fire_power, power);
        end
        tick();
        Reset_n = 1'b1;
        tick();
        press(8'd82);
        n_cmp++;
        if (power !== 8'h01 || fire_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: power=%h valid=%b expected 01 0", power, fire_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 7; i++) press(8'd82);
        n_cmp++;
        if (power !== 8'h07) begin
            n_fail++;
            $display("FAIL pwr_reach_max: power=%h expected 07", power);
        end
        press(8'd82);
        press(8'd82);
        n_cmp++;
        if (power !== 8'h07 || angle !== 8'h00) begin
            n_fail++;
            $display("FAIL pwr_saturate: power=%h angle=%h expected 07 00", power, angle);
        end
        for (int i = 0; i < 9; i++) press(8'd81);
        n_cmp++;
        if (power !== 8'h00) begin
            n_fail++;
            $display("FAIL pwr_floor: power=%h expected 00", power);
        end
        press(8'd55);
        n_cmp++;
        if (angle !== 8'h00) begin
            n_fail++;
            $display("FAIL ang_floor: angle=%h expected 00", angle);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_pwr;
`ifdef KEY_REPEAT_EN
        exp_pwr = 8'h07;
`else
        exp_pwr = 8'h01;
`endif
        do_reset();
        keycode = 8'd82;
        for (int i = 0; i < 20; i++) tick();
        keycode = 8'd0;
        tick();
        n_cmp++;
        if (power !== exp_pwr) begin
            n_fail++;
            $display("FAIL hold_20: power=%h expected %h", power, exp_pwr);
        end
    endtask

    task automatic test_isolation();
        do_reset();
        active_player = 1'b1;
        tick();
        press(8'd54);
        press(8'd54);
        press(8'd54);
        n_cmp++;
        if (angle !== 8'h30 || power !== 8'h00) begin
            n_fail++;
            $display("FAIL chan1_angle: angle=%h power=%h expected 30 00", angle, power);
        end
        is_in_turn = 1'b0;
        press(8'd54);
        n_cmp++;
        if (angle !== 8'h30) begin
            n_fail++;
            $display("FAIL out_of_turn: angle=%h expected 30", angle);
        end
        is_in_turn = 1'b1;
        keycode = 8'd54;
        active_player = 1'b0;
        tick();
        keycode = 8'd0;
        tick();
        n_cmp++;
        if (angle !== 8'h30) begin
            n_fail++;
            $display("FAIL player_switch_edge: angle=%h expected 30", angle);
        end
    endtask

    task automatic test_fire();
        do_reset();
        active_player = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) press(8'd82);
        for (int i = 0; i < 3; i++) press(8'd54);
        keycode = 8'd44;
        tick();
        keycode = 8'd0;
        n_cmp++;
        if (fire_valid !== 1'b1 || fire_player !== 1'b1 || fire_power !== 4'd5 || fire_angle !== 4'd3) begin
            n_fail++;
            $display("FAIL fire_snapshot: v=%b {%h,%h,%h} expected 1 {1,5,3}", fire_valid, fire_player, fire_power, fire_angle);
        end
        tick();
        keycode = 8'd82;
        tick();
        keycode = 8'd0;
        is_in_turn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (fire_valid !== 1'b1 || fire_player !== 1'b1 || fire_power !== 4'd5 || fire_angle !== 4'd3) begin
            n_fail++;
            $display("FAIL fire_wait_stable: v=%b {%h,%h,%h} expected 1 {1,5,3}", fire_valid, fire_player, fire_power, fire_angle);
        end
        n_cmp++;
        if (power !== 8'h50 || angle !== 8'h30) begin
            n_fail++;
            $display("FAIL fire_keys_ignored: power=%h angle=%h expected 50 30", power, angle);
        end
        is_in_turn = 1'b1;
        fire_ready = 1'b1;
        tick();
        fire_ready = 1'b0;
        n_cmp++;
        if (fire_valid !== 1'b0 || power !== 8'h50) begin
            n_fail++;
            $display("FAIL fire_handshake: valid=%b power=%h expected 0 50", fire_valid, power);
        end
        keycode = 8'd44;
        tick();
        fire_ready = 1'b1;
        tick();
        fire_ready = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (fire_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL held_fire_no_refire: valid=%b expected 0", fire_valid);
        end
        keycode = 8'd0;
        tick();
    endtask

    task automatic test_key_change();
        do_reset();
        keycode = 8'd82;
        tick();
        tick();
        tick();
        keycode = 8'd54;
        tick();
        tick();
        tick();
        keycode = 8'd0;
        tick();
        n_cmp++;
        if (power !== 8'h01 || angle !== 8'h01) begin
            n_fail++;
            $display("FAIL key_change: power=%h angle=%h expected 01 01", power, angle);
        end
    endtask

    task automatic test_turn_loss_hold();
        do_reset();
        keycode = 8'd82;
        tick();
        is_in_turn = 1'b0;
        tick();
        is_in_turn = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (power !== 8'h01) begin
            n_fail++;
            $display("FAIL held_after_turn_loss: power=%h expected 01", power);
        end
        keycode = 8'd0;
        tick();
        press(8'd82);
        n_cmp++;
        if (power !== 8'h02) begin
            n_fail++;
            $display("FAIL repress_after_release: power=%h expected 02", power);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_saturation();
        test_hold();
        test_isolation();
        test_fire();
        test_key_change();
        test_turn_loss_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
